// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared types and constants for the PC redirect controller
package pc_ctrl_pkg;

    typedef enum logic {
        RUN,
        SQUASH
    } state_t;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_HOLD,
        SRC_JUMP,
        SRC_JR,
        SRC_BR
    } src_t;

    localparam logic [1:0]  INSTR_ALIGN      = 2'b00;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/jump_target_gen.sv
// rtl/jump_target_gen.sv - combinational J/JAL and JR target formation
module jump_target_gen
    import pc_ctrl_pkg::*;
(
    input  logic [25:0] jump_field,
    input  logic [3:0]  pc_region,
    input  logic [31:0] reg_target,
    output logic [31:0] jtarget,
    output logic [31:0] jrtarget
);

    // The jump field only replaces the low 28 bits; the region never carries.
    assign jtarget  = {pc_region, jump_field, INSTR_ALIGN};
    assign jrtarget = reg_target & ~32'h0000_0003;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - PC register, redirect arbitration and squash FSM (option: DELAY_SLOT_EN)
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic [25:0] JumpField,
    input  logic [31:0] PCPlus4_ID,
    input  logic [31:0] RegTarget,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] PC,
    output logic        IFFlush,
    output logic        IDFlush,
    output logic [31:0] LinkAddr,
    output logic        Squashing
);

    state_t      state, next_state;
    src_t        src;
    logic [2:0]  cnt, next_cnt;
    logic [31:0] next_pc, jtarget, jrtarget;
    logic        if_flush, id_flush;

    jump_target_gen u_tgt (
        .jump_field (JumpField),
        .pc_region  (PCPlus4_ID[31:28]),
        .reg_target (RegTarget),
        .jtarget    (jtarget),
        .jrtarget   (jrtarget)
    );

`ifdef DELAY_SLOT_EN
    localparam bit JUMP_FLUSH = 1'b0;
    localparam bit BR_ID_FLUSH = 1'b0;
    assign LinkAddr = PCPlus4_ID + 32'd4;
`else
    localparam bit JUMP_FLUSH = 1'b1;
    localparam bit BR_ID_FLUSH = 1'b1;
    assign LinkAddr = PCPlus4_ID;
`endif

    always_comb begin
        src        = SRC_SEQ;
        if_flush   = 1'b0;
        id_flush   = 1'b0;
        next_state = state;
        next_cnt   = cnt;
        if (state == RUN) begin
            // Stall sits above the ID-stage jumps: a stalled jump waits in ID.
            if (BranchTaken) begin
                src      = SRC_BR;
                if_flush = 1'b1;
                id_flush = BR_ID_FLUSH;
                if (FLUSH_CYCLES > 1) begin
                    next_state = SQUASH;
                    next_cnt   = 3'(FLUSH_CYCLES - 1);
                end
            end else if (Stall) begin
                src = SRC_HOLD;
            end else if (JumpReg || Jump) begin
                src      = JumpReg ? SRC_JR : SRC_JUMP;
                if_flush = JUMP_FLUSH;
                if (JUMP_FLUSH && FLUSH_CYCLES > 1) begin
                    next_state = SQUASH;
                    next_cnt   = 3'(FLUSH_CYCLES - 1);
                end
            end
        end else begin
            src      = Stall ? SRC_HOLD : SRC_SEQ;
            if_flush = 1'b1;
            next_cnt = cnt - 3'd1;
            if (cnt == 3'd1) begin
                next_state = RUN;
            end
        end
    end

    always_comb begin
        next_pc = PC + 32'd4;
        case (src)
            SRC_HOLD: next_pc = PC;
            SRC_JUMP: next_pc = jtarget;
            SRC_JR:   next_pc = jrtarget;
            SRC_BR:   next_pc = BranchTarget;
            default:  next_pc = PC + 32'd4;
        endcase
    end

    assign IFFlush   = if_flush && !Reset;
    assign IDFlush   = id_flush && !Reset;
    assign Squashing = (state == SQUASH) && !Reset;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            PC    <= RESET_PC;
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            PC    <= next_pc;
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed self-checking bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;

`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset, Stall, Jump, JumpReg, BranchTaken;
    logic [25:0] JumpField;
    logic [31:0] PCPlus4_ID, RegTarget, BranchTarget;
    logic [31:0] PC, LinkAddr, PC3, LinkAddr3;
    logic        IFFlush, IDFlush, Squashing, IFFlush3, IDFlush3, Squashing3;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    pc_redirect_ctrl dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Jump(Jump), .JumpReg(JumpReg),
        .JumpField(JumpField), .PCPlus4_ID(PCPlus4_ID), .RegTarget(RegTarget),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .PC(PC),
        .IFFlush(IFFlush), .IDFlush(IDFlush), .LinkAddr(LinkAddr), .Squashing(Squashing)
    );

    pc_redirect_ctrl #(.FLUSH_CYCLES(3)) dut3 (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Jump(Jump), .JumpReg(JumpReg),
        .JumpField(JumpField), .PCPlus4_ID(PCPlus4_ID), .RegTarget(RegTarget),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .PC(PC3),
        .IFFlush(IFFlush3), .IDFlush(IDFlush3), .LinkAddr(LinkAddr3), .Squashing(Squashing3)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        Stall = 0; Jump = 0; JumpReg = 0; BranchTaken = 0;
        JumpField = '0; PCPlus4_ID = '0; RegTarget = '0; BranchTarget = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        Reset = 1;
        BranchTaken = 1;
        #2;
        total++; if (PC !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", PC, 32'h0); end
        total++; if (IFFlush !== 1'b0 || IDFlush !== 1'b0 || Squashing !== 1'b0) begin
            bad++; $display("FAIL reset_flush got=%b%b%b exp=000", IFFlush, IDFlush, Squashing);
        end
        BranchTaken = 0;
        tick();
        Reset = 0;
        #1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++; if (PC !== 32'(4 * i)) begin bad++; $display("FAIL seq_pc%0d got=%h exp=%h", i, PC, 32'(4 * i)); end
            total++; if (IFFlush !== 1'b0 || IDFlush !== 1'b0) begin
                bad++; $display("FAIL seq_flush%0d got=%b%b exp=00", i, IFFlush, IDFlush);
            end
        end
    endtask

    task automatic test_jump();
        Jump = 1; PCPlus4_ID = 32'h4000_0010; JumpField = 26'h000_0040;
        #1;
        total++; if (IFFlush !== !DS) begin bad++; $display("FAIL jump_ifflush got=%b exp=%b", IFFlush, !DS); end
        total++; if (IDFlush !== 1'b0) begin bad++; $display("FAIL jump_idflush got=%b exp=0", IDFlush); end
        total++; if (LinkAddr !== (DS ? 32'h4000_0014 : 32'h4000_0010)) begin
            bad++; $display("FAIL jump_link got=%h exp=%h", LinkAddr, DS ? 32'h4000_0014 : 32'h4000_0010);
        end
        tick();
        clear_inputs();
        #1;
        total++; if (PC !== 32'h4000_0100) begin bad++; $display("FAIL jump_pc got=%h exp=40000100", PC); end
        total++; if (IFFlush !== 1'b0) begin bad++; $display("FAIL jump_after_ifflush got=%b exp=0", IFFlush); end
    endtask

    task automatic test_branch_vs_jump();
        BranchTaken = 1; BranchTarget = 32'h0000_0200;
        Jump = 1; PCPlus4_ID = 32'h4000_0010; JumpField = 26'h000_0040;
        #1;
        total++; if (IFFlush !== 1'b1) begin bad++; $display("FAIL br_ifflush got=%b exp=1", IFFlush); end
        total++; if (IDFlush !== !DS) begin bad++; $display("FAIL br_idflush got=%b exp=%b", IDFlush, !DS); end
        tick();
        clear_inputs();
        total++; if (PC !== 32'h0000_0200) begin bad++; $display("FAIL br_pc got=%h exp=00000200", PC); end
    endtask

    task automatic test_stall_jump();
        Stall = 1; Jump = 1; PCPlus4_ID = 32'h4000_0010; JumpField = 26'h000_0040;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (IFFlush !== 1'b0) begin bad++; $display("FAIL stall_ifflush%0d got=%b exp=0", i, IFFlush); end
            tick();
            total++; if (PC !== 32'h0000_0200) begin bad++; $display("FAIL stall_pc%0d got=%h exp=00000200", i, PC); end
        end
        Stall = 0;
        #1;
        total++; if (IFFlush !== !DS) begin bad++; $display("FAIL unstall_ifflush got=%b exp=%b", IFFlush, !DS); end
        tick();
        clear_inputs();
        total++; if (PC !== 32'h4000_0100) begin bad++; $display("FAIL unstall_pc got=%h exp=40000100", PC); end
        JumpReg = 1; RegTarget = 32'h0000_1236;
        tick();
        clear_inputs();
        total++; if (PC !== 32'h0000_1234) begin bad++; $display("FAIL jr_pc got=%h exp=00001234", PC); end
    endtask

    task automatic test_wrap();
        BranchTaken = 1; BranchTarget = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        total++; if (PC !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pre got=%h exp=fffffffc", PC); end
        tick();
        total++; if (PC !== 32'h0000_0000) begin bad++; $display("FAIL wrap_pc got=%h exp=00000000", PC); end
    endtask

    task automatic test_squash_reset();
        Reset = 1;
        tick();
        Reset = 0;
        #1;
        Jump = !DS; BranchTaken = DS; BranchTarget = 32'h4000_0100;
        PCPlus4_ID = 32'h4000_0010; JumpField = 26'h000_0040;
        #1;
        total++; if (IFFlush3 !== 1'b1 || Squashing3 !== 1'b0) begin
            bad++; $display("FAIL sq_enter got=%b%b exp=10", IFFlush3, Squashing3);
        end
        tick();
        Jump = 1; BranchTaken = 0; JumpField = 26'h000_0003;
        #1;
        total++; if (PC3 !== 32'h4000_0100) begin bad++; $display("FAIL sq_pc0 got=%h exp=40000100", PC3); end
        total++; if (Squashing3 !== 1'b1 || IFFlush3 !== 1'b1 || IDFlush3 !== 1'b0) begin
            bad++; $display("FAIL sq_cycle1 got=%b%b%b exp=110", Squashing3, IFFlush3, IDFlush3);
        end
        tick();
        total++; if (PC3 !== 32'h4000_0104) begin bad++; $display("FAIL sq_ignore_jump got=%h exp=40000104", PC3); end
        total++; if (Squashing3 !== 1'b1) begin bad++; $display("FAIL sq_cycle2 got=%b exp=1", Squashing3); end
        Reset = 1;
        #1;
        total++; if (PC3 !== 32'h0 || Squashing3 !== 1'b0 || IFFlush3 !== 1'b0) begin
            bad++; $display("FAIL sq_reset got=%h/%b/%b exp=00000000/0/0", PC3, Squashing3, IFFlush3);
        end
        clear_inputs();
        tick();
        Reset = 0;
        tick();
        total++; if (PC3 !== 32'h4 || Squashing3 !== 1'b0) begin
            bad++; $display("FAIL sq_restart got=%h/%b exp=00000004/0", PC3, Squashing3);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        Reset = 1;
        @(negedge Clk);
        test_reset();
        test_jump();
        test_branch_vs_jump();
        test_stall_jump();
        test_wrap();
        test_squash_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
